// File: rtl/store_rmw_sequencer_if.sv
// -----------------------------------------------------------------------------
// store_rmw_sequencer_if
//
// Bundles every signal of the store read-modify-write sequencer except the
// clock and reset. Signal names are given from the sequencer's point of view:
// i_* are driven into the sequencer and o_* are driven out of it.
//
// Groups:
//   request  : i_req_valid, o_req_ready, i_req_addr, i_req_funct3, i_req_data
//   memory   : o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, i_mem_rdata
//   merge    : o_su_funct3, o_su_lsu_addr, o_su_mem1, o_su_mem2, o_su_data,
//              i_su_data_1, i_su_data_2
//   status   : o_done, o_err
//
// Modports:
//   slave  : the sequencer itself
//   master : the surrounding logic (execute stage, memory, merge unit)
// -----------------------------------------------------------------------------
interface store_rmw_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic [2:0]        i_req_funct3;
    logic [31:0]       i_req_data;

    logic [ADDR_W-3:0] o_mem_addr;
    logic              o_mem_re;
    logic              o_mem_we;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    logic [2:0]        o_su_funct3;
    logic [1:0]        o_su_lsu_addr;
    logic [31:0]       o_su_mem1;
    logic [31:0]       o_su_mem2;
    logic [31:0]       o_su_data;
    logic [31:0]       i_su_data_1;
    logic [31:0]       i_su_data_2;

    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_funct3, i_req_data,
        input  i_mem_rdata, i_su_data_1, i_su_data_2,
        output o_req_ready,
        output o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
        output o_su_funct3, o_su_lsu_addr, o_su_mem1, o_su_mem2, o_su_data,
        output o_done, o_err
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_funct3, i_req_data,
        output i_mem_rdata, i_su_data_1, i_su_data_2,
        input  o_req_ready,
        input  o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
        input  o_su_funct3, o_su_lsu_addr, o_su_mem1, o_su_mem2, o_su_data,
        input  o_done, o_err
    );
endinterface

// File: rtl/store_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// store_rmw_sequencer
//
// Executes RV32I stores (SB/SH/SW) as read-modify-write on a single-port,
// word-addressed data memory. One request is accepted in IDLE; the one or two
// affected words are read, handed to the external combinational merge unit
// together with the latched store data, funct3 and byte offset, and the merged
// word(s) are written back. A store whose bytes cross a word boundary touches
// base and base+1 (wrapping at the top of the word space).
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   bus (slave)   : request handshake, memory port, merge-unit port and
//                   completion status (see store_rmw_sequencer_if)
//
// Optional feature (macro STORE_FULLWORD_BYPASS_EN):
//   When defined, an aligned SW skips both reads and writes the latched store
//   data straight to memory (IDLE -> WR1 -> DONE). When undefined, every legal
//   store uses the full read-modify-write sequence.
// -----------------------------------------------------------------------------
module store_rmw_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    store_rmw_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_CAP2 = 3'd3,
        S_WR1  = 3'd4,
        S_WR2  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [31:0]       r_data;
    logic [31:0]       r_mem1;
    logic [31:0]       r_mem2;
    logic              r_span;
    logic              r_err;
`ifdef STORE_FULLWORD_BYPASS_EN
    logic              r_bypass;
    logic              w_req_bypass;
`endif

    logic              w_accept;
    logic              w_legal;
    logic              w_req_span;
    logic [1:0]        w_req_off;
    logic [ADDR_W-3:0] w_base;
    logic [ADDR_W-3:0] w_base_p1;

    assign w_accept  = bus.i_req_valid && (r_state == S_IDLE);
    assign w_req_off = bus.i_req_addr[1:0];
    assign w_legal   = (bus.i_req_funct3 == 3'b000) ||
                       (bus.i_req_funct3 == 3'b001) ||
                       (bus.i_req_funct3 == 3'b010);

    // A halfword at offset 3 or any unaligned word spills into the next word.
    assign w_req_span = ((bus.i_req_funct3 == 3'b001) && (w_req_off == 2'd3)) ||
                        ((bus.i_req_funct3 == 3'b010) && (w_req_off != 2'd0));

`ifdef STORE_FULLWORD_BYPASS_EN
    assign w_req_bypass = (bus.i_req_funct3 == 3'b010) && (w_req_off == 2'd0);
`endif

    assign w_base    = r_addr[ADDR_W-1:2];
    // Natural modulo-2^(ADDR_W-2) wrap of the word address.
    assign w_base_p1 = w_base + WORD_ONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_data   <= '0;
            r_mem1   <= '0;
            r_mem2   <= '0;
            r_span   <= 1'b0;
            r_err    <= 1'b0;
`ifdef STORE_FULLWORD_BYPASS_EN
            r_bypass <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.i_req_addr;
                        r_funct3 <= bus.i_req_funct3;
                        r_data   <= bus.i_req_data;
                        r_span   <= w_req_span;
                        // mem2 stays zero for single-word stores; the merge
                        // unit passes it through untouched.
                        r_mem2   <= '0;
`ifdef STORE_FULLWORD_BYPASS_EN
                        r_bypass <= w_legal && w_req_bypass;
`endif
                        if (!w_legal) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
`ifdef STORE_FULLWORD_BYPASS_EN
                        else if (w_req_bypass) begin
                            r_state <= S_WR1;
                        end
`endif
                        else begin
                            r_state <= S_RD1;
                        end
                    end
                end
                S_RD1: begin
                    r_state <= S_RD2;
                end
                S_RD2: begin
                    r_mem1  <= bus.i_mem_rdata;
                    r_state <= r_span ? S_CAP2 : S_WR1;
                end
                S_CAP2: begin
                    r_mem2  <= bus.i_mem_rdata;
                    r_state <= S_WR1;
                end
                S_WR1: begin
                    r_state <= r_span ? S_WR2 : S_DONE;
                end
                S_WR2: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes are decoded from state and killed by reset so that a
    // reset cycle never touches memory, even mid-sequence.
    always_comb begin
        bus.o_req_ready = (r_state == S_IDLE);
        bus.o_mem_re    = !i_rst && ((r_state == S_RD1) ||
                                     ((r_state == S_RD2) && r_span));
        bus.o_mem_we    = !i_rst && ((r_state == S_WR1) || (r_state == S_WR2));
        bus.o_mem_addr  = (((r_state == S_RD2) && r_span) || (r_state == S_WR2))
                          ? w_base_p1 : w_base;

        bus.o_mem_wdata = bus.i_su_data_1;
        if (r_state == S_WR2) begin
            bus.o_mem_wdata = bus.i_su_data_2;
        end
`ifdef STORE_FULLWORD_BYPASS_EN
        else if (r_bypass) begin
            bus.o_mem_wdata = r_data;
        end
`endif

        bus.o_done        = (r_state == S_DONE);
        bus.o_err         = (r_state == S_DONE) && r_err;

        bus.o_su_funct3   = r_funct3;
        bus.o_su_lsu_addr = r_addr[1:0];
        bus.o_su_mem1     = r_mem1;
        bus.o_su_mem2     = r_mem2;
        bus.o_su_data     = r_data;
    end
endmodule
